// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int          ITER_COUNT = 32;
    localparam logic [31:0] DIV0_Q     = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    typedef enum logic [2:0] {
        OP_MUL,
        OP_MULH,
        OP_MULHSU,
        OP_MULHU,
        OP_DIV,
        OP_DIVU,
        OP_REM,
        OP_REMU
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } muldiv_state_t;

    // Returns {sign, magnitude}; the magnitude of INT_MIN is still correct as an unsigned value.
    function automatic logic [32:0] abs_sel(input logic [31:0] value, input logic is_signed);
        logic neg;
        neg = is_signed & value[31];
        return {neg, neg ? (~value + 32'd1) : value};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-cycle shift-add multiply and restoring divide
// sharing one 64-bit working register, with early-out for divide-by-zero and overflow.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      kill,
    input  logic [2:0]                funct3,
    input  logic [DATA_WIDTH-1:0]     op_a,
    input  logic [DATA_WIDTH-1:0]     op_b,
    input  logic [REG_ADDR_WIDTH-1:0] rd_in,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_WIDTH-1:0]     result,
    output logic [REG_ADDR_WIDTH-1:0] rd_out,
    output logic                      wb_en
);

    localparam logic [4:0] LAST_COUNT = 5'(ITER_COUNT - 1);

    muldiv_state_t r_state;
    muldiv_op_t    r_op;
    logic [4:0]    r_count;
    logic [31:0]   r_operand;
    logic [63:0]   r_work;
    logic          r_negQ;
    logic          r_negR;
    logic [4:0]    r_rd;
    logic          r_busy;
    logic          r_done;
    logic          r_wbEn;
    logic [31:0]   r_result;
    logic [4:0]    r_rdOut;

    muldiv_op_t    w_reqOp;
    logic          w_reqDiv;
    logic          w_aSigned;
    logic          w_bSigned;
    logic [32:0]   w_absA;
    logic [32:0]   w_absB;
    logic          w_div0;
    logic          w_ovf;
    logic [31:0]   w_earlyRes;
    logic [32:0]   w_mulSum;
    logic [32:0]   w_remShift;
    logic          w_geq;
    logic [31:0]   w_remSub;
    logic [63:0]   w_workNext;
    logic [63:0]   w_prod;
    logic [31:0]   w_quo;
    logic [31:0]   w_rem;
    logic [31:0]   w_final;

    assign w_reqOp   = muldiv_op_t'(funct3);
    assign w_reqDiv  = funct3[2];
    assign w_aSigned = w_reqDiv ? ~funct3[0] : (w_reqOp != OP_MULHU);
    assign w_bSigned = w_reqDiv ? ~funct3[0] : ~funct3[1];
    assign w_absA    = abs_sel(op_a, w_aSigned);
    assign w_absB    = abs_sel(op_b, w_bSigned);
    assign w_div0    = w_reqDiv && (op_b == 32'd0);
    assign w_ovf     = w_reqDiv && !funct3[0] && (op_a == INT_MIN) && (op_b == 32'hFFFF_FFFF);

    always_comb begin
        w_earlyRes = 32'd0;
        if (w_div0) begin
            w_earlyRes = funct3[1] ? op_a : DIV0_Q;
        end else begin
            w_earlyRes = funct3[1] ? 32'd0 : INT_MIN;
        end
    end

    // Multiply keeps {partial sum, multiplier}; divide keeps {remainder, dividend/quotient}.
    assign w_mulSum   = {1'b0, r_work[63:32]} + (r_work[0] ? {1'b0, r_operand} : 33'd0);
    assign w_remShift = r_work[63:31];
    assign w_geq      = w_remShift >= {1'b0, r_operand};
    assign w_remSub   = w_remShift[31:0] - r_operand;

    always_comb begin
        w_workNext = {w_mulSum, r_work[31:1]};
        if (r_op[2]) begin
            w_workNext = {(w_geq ? w_remSub : w_remShift[31:0]), r_work[30:0], w_geq};
        end
    end

    assign w_prod = r_negQ ? (~w_workNext + 64'd1) : w_workNext;
    assign w_quo  = r_negQ ? (~w_workNext[31:0] + 32'd1) : w_workNext[31:0];
    assign w_rem  = r_negR ? (~w_workNext[63:32] + 32'd1) : w_workNext[63:32];

    always_comb begin
        w_final = 32'd0;
        case (r_op)
            OP_MUL:                     w_final = w_prod[31:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:                   w_final = w_prod[63:32];
            OP_DIV, OP_DIVU:            w_final = w_quo;
            OP_REM, OP_REMU:            w_final = w_rem;
            default:                    w_final = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_op      <= OP_MUL;
            r_count   <= 5'd0;
            r_operand <= 32'd0;
            r_work    <= 64'd0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_rd      <= 5'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wbEn    <= 1'b0;
            r_result  <= 32'd0;
            r_rdOut   <= 5'd0;
        end else begin
            r_done <= 1'b0;
            r_wbEn <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !kill) begin
                        r_op      <= w_reqOp;
                        r_rd      <= rd_in;
                        r_busy    <= 1'b1;
                        r_count   <= 5'd0;
                        r_negQ    <= w_absA[32] ^ w_absB[32];
                        r_negR    <= w_absA[32];
                        r_operand <= w_reqDiv ? w_absB[31:0] : w_absA[31:0];
                        r_work    <= {32'd0, (w_reqDiv ? w_absA[31:0] : w_absB[31:0])};
                        if (w_div0 || w_ovf) begin
                            r_state  <= DONE;
                            r_done   <= 1'b1;
                            r_wbEn   <= (rd_in != 5'd0);
                            r_result <= w_earlyRes;
                            r_rdOut  <= rd_in;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (kill) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_count <= 5'd0;
                    end else begin
                        r_work  <= w_workNext;
                        r_count <= r_count + 5'd1;
                        if (r_count == LAST_COUNT) begin
                            r_state  <= DONE;
                            r_done   <= 1'b1;
                            r_wbEn   <= (r_rd != 5'd0);
                            r_result <= w_final;
                            r_rdOut  <= r_rd;
                            r_count  <= 5'd0;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign wb_en  = r_wbEn;
    assign result = r_result;
    assign rd_out = r_rdOut;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit: expected results come from a behavioural RV32M model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] result;
        logic [4:0]  rd;
        int          latency;
    } sbEntry;

    logic        clk;
    logic        rst;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        wb_en;

    int          checks;
    int          errors;
    sbEntry      sb[$];
    logic [31:0] lastResult;

    muldiv_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .busy(busy), .done(done),
        .result(result), .rd_out(rd_out), .wb_en(wb_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] modelResult(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb2;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        p   = 64'd0;
        case (f)
            3'd0: begin p = sa * sb2; return p[31:0]; end
            3'd1: begin p = sa * sb2; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = sa / sb2; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                p = sa % sb2; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives start for one cycle (cycle 0), then scrambles operands to prove they were captured.
    task automatic applyStimulus(input string tag, input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd);
        sbEntry e;
        logic   early;
        @(negedge clk);
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        early  = f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        e.tag     = tag;
        e.result  = modelResult(f, a, b);
        e.rd      = rd;
        e.latency = early ? 1 : 33;
        sb.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
        rd_in  = 5'($urandom);
    endtask

    task automatic waitDone(input int startCycle);
        int     cyc;
        int     busyLow;
        sbEntry e;
        cyc     = startCycle;
        busyLow = 0;
        while (done !== 1'b1 && cyc < startCycle + 40) begin
            if (busy !== 1'b1) busyLow++;
            @(negedge clk);
            cyc++;
        end
        if (sb.size() == 0) begin
            checkOutput("scoreboard empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        checkOutput({e.tag, " done"}, 32'(done), 32'd1);
        if (done === 1'b1) begin
            if (busy !== 1'b1) busyLow++;
            checkOutput({e.tag, " latency"}, 32'(cyc), 32'(e.latency));
            checkOutput({e.tag, " result"}, result, e.result);
            checkOutput({e.tag, " rd_out"}, 32'(rd_out), 32'(e.rd));
            checkOutput({e.tag, " wb_en"}, 32'(wb_en), 32'(e.rd != 5'd0));
            checkOutput({e.tag, " busy low cycles"}, 32'(busyLow), 32'd0);
            lastResult = e.result;
        end
    endtask

    initial begin
        int doneSeen;
        checks     = 0;
        errors     = 0;
        lastResult = 32'd0;
        rst    = 1'b1;
        start  = 1'b0;
        kill   = 1'b0;
        funct3 = 3'd0;
        op_a   = 32'd0;
        op_b   = 32'd0;
        rd_in  = 5'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset wb_en", 32'(wb_en), 32'd0);
        checkOutput("reset result", result, 32'd0);
        checkOutput("reset rd_out", 32'(rd_out), 32'd0);
        rst = 1'b0;

        applyStimulus("MUL", OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5);
        waitDone(1);
        @(negedge clk);
        checkOutput("MUL done pulse", 32'(done), 32'd0);
        checkOutput("MUL busy release", 32'(busy), 32'd0);

        // Consecutive calls below start in the IDLE cycle right after DONE.
        applyStimulus("MULH", OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd1);
        waitDone(1);
        applyStimulus("MULHU", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        waitDone(1);
        applyStimulus("MULHSU", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd3);
        waitDone(1);
        applyStimulus("DIVU", OP_DIVU, 32'd100, 32'd7, 5'd4);
        waitDone(1);
        applyStimulus("REMU", OP_REMU, 32'd100, 32'd7, 5'd6);
        waitDone(1);
        applyStimulus("DIV", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7);
        waitDone(1);
        applyStimulus("REM", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd8);
        waitDone(1);
        applyStimulus("DIV0", OP_DIV, 32'd5, 32'd0, 5'd9);
        waitDone(1);
        applyStimulus("REMU0", OP_REMU, 32'd5, 32'd0, 5'd11);
        waitDone(1);
        applyStimulus("DIVOVF", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        waitDone(1);
        applyStimulus("REMOVF", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        waitDone(1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("RAND%0d", i), 3'($urandom), $urandom, $urandom_range(1, 1000), 5'($urandom));
            waitDone(1);
        end

        applyStimulus("HS", OP_DIVU, 32'd1000, 32'd3, 5'd9);
        repeat (9) @(negedge clk);
        start  = 1'b1;
        funct3 = OP_MUL;
        op_a   = 32'd2;
        op_b   = 32'd2;
        rd_in  = 5'd4;
        @(negedge clk);
        start = 1'b0;
        waitDone(11);
        repeat (3) @(negedge clk);
        checkOutput("HS no extra op", 32'(busy), 32'd0);

        applyStimulus("RD0", OP_MUL, 32'd3, 32'd4, 5'd0);
        waitDone(1);
        applyStimulus("RD10", OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd10);
        waitDone(1);

        applyStimulus("KILL", OP_DIVU, 32'd50, 32'd5, 5'd7);
        void'(sb.pop_back());
        repeat (14) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        checkOutput("KILL busy", 32'(busy), 32'd0);
        checkOutput("KILL done", 32'(done), 32'd0);
        checkOutput("KILL result kept", result, lastResult);
        doneSeen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) doneSeen++;
        end
        checkOutput("KILL no late done", 32'(doneSeen), 32'd0);

        @(negedge clk);
        start  = 1'b1;
        kill   = 1'b1;
        funct3 = OP_DIV;
        op_a   = 32'd5;
        op_b   = 32'd0;
        @(negedge clk);
        start = 1'b0;
        kill  = 1'b0;
        checkOutput("IDLE kill busy", 32'(busy), 32'd0);
        checkOutput("IDLE kill done", 32'(done), 32'd0);

        applyStimulus("RST", OP_MUL, 32'd9, 32'd9, 5'd12);
        void'(sb.pop_back());
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("RST busy", 32'(busy), 32'd0);
        checkOutput("RST done", 32'(done), 32'd0);
        checkOutput("RST wb_en", 32'(wb_en), 32'd0);
        checkOutput("RST result", result, 32'd0);
        checkOutput("RST rd_out", 32'(rd_out), 32'd0);

        applyStimulus("POSTRST", OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd3);
        waitDone(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two register-file read operands and a destination register index.
- Produces a 32-bit result with a one-cycle write-back strobe that drives the register file's write address, data and enable inputs.
- Operation is multi-cycle. The controller stalls on busy and accepts the result on done.

Parameters:
- DATA_WIDTH, 32, operand/result width (only 32 is supported).
- REG_ADDR_WIDTH, 5, destination register index width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- kill  input  1  abort the in-flight operation (branch flush)
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  32  rs1 value
- op_b  input  32  rs2 value
- rd_in  input  5  destination register index
- busy  output  1  high while not IDLE
- done  output  1  one-cycle pulse; result valid
- result  output  32  operation result
- rd_out  output  5  captured destination index
- wb_en  output  1  equals done, except forced 0 when rd_out==0

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst), and takes priority over all other inputs.
- Reset values: state=IDLE, busy=0, done=0, wb_en=0, result=0, rd_out=0, counter=0.
- States and transitions:
  - IDLE: on start=1, capture funct3, op_a, op_b, rd_in, then go to CALC.
  - IDLE, divide by zero or signed overflow: go to DONE instead of CALC (early out).
  - CALC: 32 iterations, one per cycle, counter 0..31. Go to DONE after counter==31.
  - DONE: one cycle, done=1, then IDLE.
- Latency: start sampled at the edge ending cycle 0. Normal ops have done=1 in cycle 33. Early-out ops have done=1 in cycle 1.
- Handshake:
  - start while busy=1 is ignored and causes no side effect.
  - Back-to-back start is accepted in the IDLE cycle following DONE.
- Multiply:
  - Shift-add on magnitudes into a 64-bit product.
  - Signedness: MUL/MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - Sign correction (two's-complement negate of the 64-bit product) is applied when latching result on entry to DONE.
  - MUL returns product[31:0]. MULH/MULHSU/MULHU return product[63:32].
- Divide:
  - Restoring division on magnitudes, producing a 32-bit quotient and remainder.
  - Signed quotient is negative iff operand signs differ.
  - Signed remainder takes the sign of the dividend.
- Special cases (RISC-V defined, no trap):
  - Divide by zero: DIV/DIVU=0xFFFFFFFF, REM/REMU=op_a.
  - Signed overflow (DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF): DIV=0x80000000, REM=0.
- result and rd_out hold their value after DONE until the next DONE. They are not cleared on start.
- kill:
  - In CALC: go to IDLE next edge, no done, result unchanged.
  - In DONE: done still asserts this cycle, because the result is already committed.
  - In IDLE with start=1: kill wins; the request is dropped.
- rst mid-operation: immediate return to reset values at the next edge. No done.
- Operand changes after capture have no effect.

Decomposition:
- muldiv_pkg holds:
  - funct3 encoding enum muldiv_op_t, in the order listed above.
  - state enum muldiv_state_t {IDLE, CALC, DONE}.
  - ITER_COUNT=32.
  - Special constants DIV0_Q=32'hFFFFFFFF and INT_MIN=32'h80000000.
- No sub-module is required. Multiply and divide share the 64-bit working register and the counter in one module.
- Optional helper function in the package: abs_sel(value, is_signed), which returns the magnitude and a sign bit.

Test Plan:
- MUL: op_a=7, op_b=0xFFFFFFFD (-3) -> result=0xFFFFFFEB, done in cycle 33, busy 1 in cycles 1..33.
- MULH: 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- DIVU 100/7 -> 14 and REMU -> 2. DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF.
- Early out:
  - DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with done in cycle 1.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, each with done in cycle 1.
- Handshake: second start with different operands at cycle 10 -> ignored, first result correct. rd_in=0 -> done=1, wb_en=0. rd_in=10 -> rd_out=10, wb_en pulses.
- Abort:
  - kill at cycle 15 -> IDLE at cycle 16, no done, result keeps the previous value.
  - rst at cycle 20 -> all outputs 0 next cycle. A new op afterwards completes correctly.
